// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared op encodings, FSM state type and default width for the iterative arithmetic unit
package arith_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one combinational shift-add multiply or restoring divide iteration
module muldiv_step
    import arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               is_div,
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    output logic [WIDTH-1:0]   hi_next,
    output logic [WIDTH-1:0]   lo_next
);

    // acc holds {partial product, remaining multiplier} for mul and
    // {partial remainder, remaining dividend / growing quotient} for div.
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shifted;
    logic [WIDTH-1:0] div_diff;
    logic             div_fits;

    assign hi = acc[2*WIDTH-1:WIDTH];
    assign lo = acc[WIDTH-1:0];

    // Select between one multiply step and one divide step.
    always_comb begin
        mul_sum     = {1'b0, hi} + {1'b0, (lo[0] ? operand : {WIDTH{1'b0}})};
        div_shifted = {hi, lo[WIDTH-1]};
        div_fits    = (div_shifted >= {1'b0, operand});
        // When the divisor fits, the difference is below the divisor and so fits in WIDTH bits.
        div_diff    = div_shifted[WIDTH-1:0] - operand;
        if (is_div) begin
            hi_next = div_fits ? div_diff : div_shifted[WIDTH-1:0];
            lo_next = {lo[WIDTH-2:0], div_fits};
        end else begin
            hi_next = mul_sum[WIDTH:1];
            lo_next = {mul_sum[0], lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/iter_arith_unit.sv
// rtl/iter_arith_unit.sv - add/sub in one cycle, mul/div iterated one bit per cycle
module iter_arith_unit
    import arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               CLK,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   opA,
    input  logic [WIDTH-1:0]   opB,
    input  logic [1:0]         module_select,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result,
    output logic               div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_t             state;
    logic [1:0]         op_q;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   operand_q;
    logic [CNT_W-1:0]   iter_cnt;
    logic [WIDTH-1:0]   hi_next;
    logic [WIDTH-1:0]   lo_next;

    muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .is_div  (op_q == OP_DIV),
        .acc     (acc),
        .operand (operand_q),
        .hi_next (hi_next),
        .lo_next (lo_next)
    );

    assign busy = (state != IDLE);

    // Control FSM: accept in IDLE, iterate in CALC, pulse done for one cycle in DONE.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state       <= IDLE;
            done        <= 1'b0;
            result      <= '0;
            div_by_zero <= 1'b0;
            iter_cnt    <= '0;
            acc         <= '0;
            operand_q   <= '0;
            op_q        <= OP_ADD;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_q     <= module_select;
                        iter_cnt <= '0;
                        case (module_select)
                            OP_ADD: begin
                                result      <= {{(WIDTH-1){1'b0}}, ({1'b0, opA} + {1'b0, opB})};
                                div_by_zero <= 1'b0;
                                done        <= 1'b1;
                                state       <= DONE;
                            end
                            OP_SUB: begin
                                result      <= {{WIDTH{1'b0}}, opA} - {{WIDTH{1'b0}}, opB};
                                div_by_zero <= 1'b0;
                                done        <= 1'b1;
                                state       <= DONE;
                            end
                            OP_MUL: begin
                                // Multiplier sits in the low half and is consumed LSB first.
                                acc       <= {{WIDTH{1'b0}}, opB};
                                operand_q <= opA;
                                state     <= CALC;
                            end
                            OP_DIV: begin
                                if (opB == '0) begin
                                    result      <= {opA, {WIDTH{1'b1}}};
                                    div_by_zero <= 1'b1;
                                    done        <= 1'b1;
                                    state       <= DONE;
                                end else begin
                                    // Dividend sits in the low half and is consumed MSB first.
                                    acc       <= {{WIDTH{1'b0}}, opA};
                                    operand_q <= opB;
                                    state     <= CALC;
                                end
                            end
                        endcase
                    end
                end
                CALC: begin
                    acc      <= {hi_next, lo_next};
                    iter_cnt <= iter_cnt + CNT_W'(1);
                    // The last iteration writes straight into result so done lands on DONE entry.
                    if (iter_cnt == CNT_W'(WIDTH - 1)) begin
                        result      <= {hi_next, lo_next};
                        div_by_zero <= 1'b0;
                        done        <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iter_arith_unit.sv
// tb/tb_iter_arith_unit.sv - directed vector bench for iter_arith_unit
module tb_iter_arith_unit;

    localparam int W = 32;

    logic          CLK;
    logic          reset;
    logic          start;
    logic [W-1:0]  opA;
    logic [W-1:0]  opB;
    logic [1:0]    module_select;
    logic          busy;
    logic          done;
    logic [2*W-1:0] result;
    logic          div_by_zero;

    int n_tests;
    int n_fail;

    iter_arith_unit #(.WIDTH(W)) dut (
        .CLK           (CLK),
        .reset         (reset),
        .start         (start),
        .opA           (opA),
        .opB           (opB),
        .module_select (module_select),
        .busy          (busy),
        .done          (done),
        .result        (result),
        .div_by_zero   (div_by_zero)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [1:0]     sel;
        logic [2*W-1:0] exp_res;
        logic           exp_dbz;
        int             exp_lat;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Issue one op from IDLE, wait for done (bounded), return what was seen.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] sel,
                          output logic [2*W-1:0] res, output logic dbz, output int lat,
                          output logic busy_ok);
        opA = a;
        opB = b;
        module_select = sel;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 1;
        busy_ok = 1'b1;
        while (!done && lat < 100) begin
            if (!busy) busy_ok = 1'b0;
            tick();
            lat++;
        end
        if (!busy) busy_ok = 1'b0;
        res = result;
        dbz = div_by_zero;
    endtask

    initial begin
        logic [2*W-1:0] res;
        logic           dbz;
        int             lat;
        logic           busy_ok;
        logic           saw_done;

        n_tests = 0;
        n_fail = 0;
        reset = 1'b1;
        start = 1'b0;
        opA = '0;
        opB = '0;
        module_select = 2'b00;

        vecs[0]  = '{32'hFFFF_FFFF, 32'h1,         2'b00, 64'h0000_0001_0000_0000, 1'b0, 1};
        vecs[1]  = '{32'h0,         32'h0,         2'b00, 64'h0,                   1'b0, 1};
        vecs[2]  = '{32'h1234_5678, 32'h1111_1111, 2'b00, 64'h0000_0000_2345_6789, 1'b0, 1};
        vecs[3]  = '{32'h5,         32'h7,         2'b01, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1};
        vecs[4]  = '{32'h7,         32'h5,         2'b01, 64'h2,                   1'b0, 1};
        vecs[5]  = '{32'h0,         32'h0,         2'b01, 64'h0,                   1'b0, 1};
        vecs[6]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b10, 64'hFFFF_FFFE_0000_0001, 1'b0, 33};
        vecs[7]  = '{32'h3,         32'h5,         2'b10, 64'hF,                   1'b0, 33};
        vecs[8]  = '{32'h0001_0000, 32'h0001_0000, 2'b10, 64'h0000_0001_0000_0000, 1'b0, 33};
        vecs[9]  = '{32'd100,       32'd7,         2'b11, 64'h0000_0002_0000_000E, 1'b0, 33};
        vecs[10] = '{32'd100,       32'd0,         2'b11, 64'h0000_0064_FFFF_FFFF, 1'b1, 1};
        vecs[11] = '{32'd7,         32'd100,       2'b11, 64'h0000_0007_0000_0000, 1'b0, 33};
        vecs[12] = '{32'hFFFF_FFFF, 32'h1,         2'b11, 64'h0000_0000_FFFF_FFFF, 1'b0, 33};
        vecs[13] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b11, 64'h1,                   1'b0, 33};

        // Reset state
        tick();
        tick();
        reset = 1'b0;
        check("reset_busy", {63'h0, busy}, 64'h0);
        check("reset_done", {63'h0, done}, 64'h0);
        check("reset_result", result, 64'h0);
        check("reset_dbz", {63'h0, div_by_zero}, 64'h0);

        // Table-driven vectors
        for (int i = 0; i < 14; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].sel, res, dbz, lat, busy_ok);
            check($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
            check($sformatf("v%0d_result", i), res, vecs[i].exp_res);
            check($sformatf("v%0d_dbz", i), {63'h0, dbz}, {63'h0, vecs[i].exp_dbz});
            check($sformatf("v%0d_busy_inflight", i), {63'h0, busy_ok}, 64'h1);
            tick();
            check($sformatf("v%0d_done_pulse", i), {63'h0, done}, 64'h0);
            check($sformatf("v%0d_idle_busy", i), {63'h0, busy}, 64'h0);
            check($sformatf("v%0d_held", i), result, vecs[i].exp_res);
        end

        // Back-to-back adds with start held high: accepts on every other edge
        opA = 32'd1;
        opB = 32'd2;
        module_select = 2'b00;
        start = 1'b1;
        tick();
        check("b2b_done0", {63'h0, done}, 64'h1);
        check("b2b_res0", result, 64'd3);
        opA = 32'd10;
        opB = 32'd20;
        tick();
        check("b2b_gap_done", {63'h0, done}, 64'h0);
        check("b2b_gap_busy", {63'h0, busy}, 64'h0);
        check("b2b_gap_res", result, 64'd3);
        tick();
        check("b2b_done1", {63'h0, done}, 64'h1);
        check("b2b_res1", result, 64'd30);
        start = 1'b0;
        tick();

        // start during CALC ignored; operand changes after accept have no effect
        opA = 32'd3;
        opB = 32'd5;
        module_select = 2'b10;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 1;
        repeat (4) begin
            tick();
            lat++;
        end
        opA = 32'd7;
        opB = 32'd9;
        module_select = 2'b00;
        start = 1'b1;
        tick();
        lat++;
        start = 1'b0;
        opA = 32'hDEAD_BEEF;
        opB = 32'h1234_5678;
        check("ignore_no_early_done", {63'h0, done}, 64'h0);
        while (!done && lat < 100) begin
            tick();
            lat++;
        end
        check("ignore_latency", 64'(lat), 64'd33);
        check("ignore_result", result, 64'd15);
        tick();

        // Reset at CALC cycle 10 abandons the multiply
        run_op(32'd4, 32'd5, 2'b00, res, dbz, lat, busy_ok);
        tick();
        opA = 32'hFFFF_FFFF;
        opB = 32'hFFFF_FFFF;
        module_select = 2'b10;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        check("rst_mid_busy_before", {63'h0, busy}, 64'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_mid_busy", {63'h0, busy}, 64'h0);
        check("rst_mid_result", result, 64'h0);
        check("rst_mid_done", {63'h0, done}, 64'h0);
        saw_done = 1'b0;
        repeat (40) begin
            tick();
            if (done) saw_done = 1'b1;
        end
        check("rst_mid_no_done", {63'h0, saw_done}, 64'h0);
        run_op(32'd2, 32'd3, 2'b00, res, dbz, lat, busy_ok);
        check("post_rst_add_lat", 64'(lat), 64'd1);
        check("post_rst_add_res", res, 64'd5);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/iter_arith_unit.md
ITER_ARITH_UNIT -- requirements
Module: iter_arith_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width; result width is 2*WIDTH.
REQ-002 SHALL have port CLK  input  1  system clock, all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port opA  input  WIDTH  operand A, unsigned.
REQ-006 SHALL have port opB  input  WIDTH  operand B, unsigned.
REQ-007 SHALL have port module_select  input  2  op: 00 add, 01 sub, 10 mul, 11 div.
REQ-008 SHALL have port busy  output  1  high while an accepted operation is in flight, including its DONE cycle.
REQ-009 SHALL have port done  output  1  single-cycle pulse, result valid.
REQ-010 SHALL have port result  output  2*WIDTH  registered result, held until the next completion.
REQ-011 SHALL have port div_by_zero  output  1  set with done when op=div and opB=0; held with result.

Function
REQ-012 SHALL implement FSM states IDLE, CALC, DONE.
REQ-013 IDLE: start=1 at an edge SHALL latch opA, opB and module_select; go to DONE for add, sub, or div with opB=0; otherwise go to CALC with iteration count=0.
REQ-014 CALC SHALL perform one iteration per cycle for exactly WIDTH cycles, then enter DONE.
REQ-015 DONE SHALL last one cycle with done=1, result and div_by_zero updated on entry, then return to IDLE.
REQ-016 Latency, start edge to the first cycle with done=1: add/sub/div-by-zero 1 cycle; mul/div WIDTH+1 cycles.
REQ-017 start SHALL be ignored in CALC and DONE, with no queuing; back-to-back accepts are possible every 2 cycles for add/sub.
REQ-018 Operand inputs changing after acceptance SHALL NOT affect the in-flight result.
REQ-019 add: result = zero-extended (WIDTH+1)-bit sum, carry in bit WIDTH.
REQ-020 sub: result = opA-opB as a 2*WIDTH-bit two's-complement value, upper half all ones when opB>opA.
REQ-021 mul: result = unsigned 2*WIDTH-bit product, computed by shift-add with one partial product per CALC cycle.
REQ-022 div: restoring division, one quotient bit per CALC cycle; result = {remainder, quotient}.
REQ-023 div with opB=0: quotient all ones, remainder = opA, div_by_zero=1.
REQ-024 div_by_zero SHALL be cleared on any other completion.
REQ-025 busy SHALL be the registered state != IDLE.

Reset
REQ-026 reset=1 at an edge SHALL force IDLE, busy=0, done=0, result=0, div_by_zero=0 and iteration count=0, and SHALL take priority over start.
REQ-027 reset mid-CALC SHALL abandon the operation, emitting no done pulse and not updating result.

Structure
REQ-028 Package arith_pkg SHALL hold the op encodings (OP_ADD, OP_SUB, OP_MUL, OP_DIV), the FSM state typedef and the default WIDTH.
REQ-029 A combinational sub-module muldiv_step SHALL compute one mul/div iteration: accumulator/remainder and shifted-operand next values.
REQ-030 The iteration counter SHALL be clog2(WIDTH)+1 bits wide.

Verification
REQ-031 Add: opA=FFFFFFFF, opB=1, start -> one cycle later done=1, result=0x0000000100000000.
REQ-032 Sub: opA=5, opB=7 -> done after 1 cycle, result=0xFFFFFFFFFFFFFFFE.
REQ-033 Mul: opA=FFFFFFFF, opB=FFFFFFFF -> done exactly 33 cycles after start, result=0xFFFFFFFE00000001, busy high for cycles 1-33.
REQ-034 Div: opA=100, opB=7 -> done at cycle 33, result={14 remainder... i.e. rem=2, quot=14} = 0x000000020000000E; opB=0 -> done at cycle 1, result=0x00000064FFFFFFFF, div_by_zero=1.
REQ-035 start pulsed during CALC with different operands -> ignored, original result delivered.
REQ-036 reset asserted at CALC cycle 10 -> next cycle busy=0, result=0, no done; a following add completes normally.
